// File: rtl/keypad_4x4_entry_if.sv
// rtl/keypad_4x4_entry_if.sv - signal bundle between keypad entry block and its surroundings
//
// Purpose: groups the keypad matrix lines and the entry/commit outputs.
// Ports (slave = keypad_4x4_entry side):
//   row_in      4   keypad rows, active-low, asynchronous
//   col_out     4   column strobes, active-low one-hot
//   key_code    4   code of last accepted key
//   key_strobe  1   1-cycle pulse on accepted press
//   entry       14  live value of digits entered so far
//   digit_count 3   digits entered so far, 0..4
//   value       14  last committed value
//   value_valid 1   1-cycle pulse when value updates
interface keypad_4x4_entry_if;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_strobe;
  logic [13:0] entry;
  logic [2:0]  digit_count;
  logic [13:0] value;
  logic        value_valid;

  modport master (
    output row_in,
    input  col_out, key_code, key_strobe, entry, digit_count, value, value_valid
  );

  modport slave (
    input  row_in,
    output col_out, key_code, key_strobe, entry, digit_count, value, value_valid
  );
endinterface

// File: rtl/keypad_4x4_entry.sv
// rtl/keypad_4x4_entry.sv - 4x4 keypad scanner, debouncer and 4-digit decimal entry
//
// Purpose: scans a 4x4 matrix keypad, debounces whole-frame results and
// assembles up to four decimal digits into a 14-bit binary value.
// '*' clears the entry, '#' commits it to value.
// Ports:
//   clk  system clock
//   rst  synchronous reset, active-high
//   bus  keypad_4x4_entry_if.slave (rows in, columns/key/entry/value out)
module keypad_4x4_entry #(
  parameter int SCAN_DIV_BITS  = 17,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              rst,
  keypad_4x4_entry_if.slave bus
);

  localparam int CNT_W = SCAN_DIV_BITS + 2;
  localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DB_W-1:0] DB_ONE    = DB_W'(1);
  localparam logic [DB_W-1:0] DB_TARGET = DB_W'(DEBOUNCE_SCANS);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  logic [3:0]       row_meta;
  logic [3:0]       row_sync;
  logic [CNT_W-1:0] scan_cnt;
  logic [1:0]       col;
  logic             slot_end;
  logic             frame_end;

  // Per-frame accumulation: hit_cnt saturates at 2 meaning "more than one"
  logic [1:0]       hit_cnt;
  logic [3:0]       hit_key;
  logic [2:0]       col_hits;
  logic [1:0]       hit_row;
  logic [1:0]       sum_cnt;
  logic [3:0]       sum_key;
  logic             frame_valid;

  logic [1:0]       state;
  logic [3:0]       cand;
  logic [DB_W-1:0]  db_cnt;
  logic [3:0]       key_code;
  logic             key_strobe;

  logic [13:0]      entry;
  logic [2:0]       digit_count;
  logic [13:0]      value;
  logic             value_valid;
  logic [13:0]      entry_x10;

  function automatic logic [3:0] key_lut(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0:    k = 4'd1;
      4'h1:    k = 4'd2;
      4'h2:    k = 4'd3;
      4'h3:    k = 4'd10;
      4'h4:    k = 4'd4;
      4'h5:    k = 4'd5;
      4'h6:    k = 4'd6;
      4'h7:    k = 4'd11;
      4'h8:    k = 4'd7;
      4'h9:    k = 4'd8;
      4'ha:    k = 4'd9;
      4'hb:    k = 4'd12;
      4'hc:    k = 4'd14;
      4'hd:    k = 4'd0;
      4'he:    k = 4'd15;
      default: k = 4'd13;
    endcase
    return k;
  endfunction

  assign col       = scan_cnt[CNT_W-1 -: 2];
  // Sample on the last cycle of a slot so the rows have settled through the synchronizer
  assign slot_end  = &scan_cnt[SCAN_DIV_BITS-1:0];
  assign frame_end = slot_end && (col == 2'd3);

  always_comb begin
    col_hits = 3'd0;
    hit_row  = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (!row_sync[r]) begin
        col_hits = col_hits + 3'd1;
        hit_row  = 2'(r);
      end
    end
  end

  // Frame result including the column being sampled this cycle
  always_comb begin
    sum_key = hit_key;
    if (col_hits == 3'd0) begin
      sum_cnt = hit_cnt;
    end else if (col_hits == 3'd1 && hit_cnt == 2'd0) begin
      sum_cnt = 2'd1;
      sum_key = key_lut(hit_row, col);
    end else begin
      sum_cnt = 2'd2;
    end
  end

  assign frame_valid = (sum_cnt == 2'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta   <= 4'hf;
      row_sync   <= 4'hf;
      scan_cnt   <= '0;
      hit_cnt    <= 2'd0;
      hit_key    <= 4'd0;
      state      <= ST_IDLE;
      cand       <= 4'd0;
      db_cnt     <= '0;
      key_code   <= 4'd0;
      key_strobe <= 1'b0;
    end else begin
      row_meta   <= bus.row_in;
      row_sync   <= row_meta;
      scan_cnt   <= scan_cnt + CNT_W'(1);
      key_strobe <= 1'b0;

      if (slot_end) begin
        if (frame_end) begin
          hit_cnt <= 2'd0;
          hit_key <= 4'd0;
        end else begin
          hit_cnt <= sum_cnt;
          hit_key <= sum_key;
        end
      end

      if (frame_end) begin
        case (state)
          ST_IDLE: begin
            if (frame_valid) begin
              cand   <= sum_key;
              db_cnt <= DB_ONE;
              if (DB_ONE == DB_TARGET) begin
                key_strobe <= 1'b1;
                key_code   <= sum_key;
                state      <= ST_HELD;
              end else begin
                state <= ST_DEBOUNCE;
              end
            end
          end
          ST_DEBOUNCE: begin
            if (frame_valid && sum_key == cand) begin
              db_cnt <= db_cnt + DB_ONE;
              if (db_cnt + DB_ONE == DB_TARGET) begin
                key_strobe <= 1'b1;
                key_code   <= cand;
                state      <= ST_HELD;
              end
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_HELD: begin
            // Any key (even a different one) keeps us held: no auto-repeat
            if (!frame_valid) begin
              db_cnt <= DB_ONE;
              state  <= (DB_ONE == DB_TARGET) ? ST_IDLE : ST_RELEASE;
            end
          end
          ST_RELEASE: begin
            if (frame_valid) begin
              state <= ST_HELD;
            end else begin
              db_cnt <= db_cnt + DB_ONE;
              if (db_cnt + DB_ONE == DB_TARGET) state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // entry*10 + d as shifts and adds; never exceeds 9999 because of the 4-digit limit
  assign entry_x10 = (entry << 3) + (entry << 1) + {10'd0, key_code};

  always_ff @(posedge clk) begin
    if (rst) begin
      entry       <= 14'd0;
      digit_count <= 3'd0;
      value       <= 14'd0;
      value_valid <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      if (key_strobe) begin
        if (key_code <= 4'd9) begin
          if (digit_count != 3'd4) begin
            entry       <= entry_x10;
            digit_count <= digit_count + 3'd1;
          end
        end else if (key_code == 4'd14) begin
          entry       <= 14'd0;
          digit_count <= 3'd0;
        end else if (key_code == 4'd15) begin
          value       <= entry;
          value_valid <= 1'b1;
          entry       <= 14'd0;
          digit_count <= 3'd0;
        end
      end
    end
  end

  assign bus.col_out     = ~(4'b0001 << col);
  assign bus.key_code    = key_code;
  assign bus.key_strobe  = key_strobe;
  assign bus.entry       = entry;
  assign bus.digit_count = digit_count;
  assign bus.value       = value;
  assign bus.value_valid = value_valid;

endmodule
